// File: rtl/loader_pkg.sv
// Shared types for the program loader: FSM states and error codes.
// Imported by program_loader and loader_timeout.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    // True while a frame is being received (idle watchdog armed).
    function automatic logic is_busy_state(input state_t s);
        return (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle watchdog: counts enabled cycles since the last clear.
// Ports: clk, rst (async high), clr, en in; expired out.
module loader_timeout
    import loader_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // Fires in the LIMIT-th idle cycle; a clear in the
    // same cycle (accepted byte) takes priority.
    assign expired = en && !clr && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || expired) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Frame receiver that writes a SYNC/LEN/payload/CSUM stream into program RAM.
// Ports: clk, rst, in_valid/in_data/in_ready stream; ram_addr/ram_data/ram_we; cpu_rst, busy, done, error.
module program_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
    parameter int                TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic [1:0]        error
);

    localparam int MAX_LEN = 2 ** ADDR_W;
    // LEN is never truncated before the range check.
    localparam int LW = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;
    localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] sum;

    logic              accept;
    logic              is_sync;
    logic [LW-1:0]     len_in;
    logic              len_bad;
    logic              tmo_en;
    logic              tmo_exp;
    logic              fail;
    logic [1:0]        fail_code;

    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            IDLE, LEN, DATA,
            CSUM, DONE, ERR: in_ready = 1'b1;
            default:         in_ready = 1'b0;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign is_sync = (in_data == SYNC_BYTE);
    assign len_in  = LW'(in_data);
    assign len_bad = (len_in == '0) || (len_in > LW'(MAX_LEN));
    assign tmo_en  = is_busy_state(state);

    loader_timeout #(
        .LIMIT   (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .en      (tmo_en),
        .expired (tmo_exp)
    );

    // Every path into ERR, with its code. tmo_exp is already
    // masked by accept, so an arriving byte beats the timeout.
    always_comb begin
        fail      = 1'b0;
        fail_code = ERR_NONE;
        unique case (state)
            LEN: begin
                if (accept && len_bad) begin
                    fail      = 1'b1;
                    fail_code = ERR_LEN;
                end else if (tmo_exp) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end
            end
            DATA: begin
                if (tmo_exp) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end
            end
            CSUM: begin
                if (accept && (in_data != sum)) begin
                    fail      = 1'b1;
                    fail_code = ERR_CSUM;
                end else if (tmo_exp) begin
                    fail      = 1'b1;
                    fail_code = ERR_TMO;
                end
            end
            default: begin
                fail      = 1'b0;
                fail_code = ERR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            sum       <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_we    <= 1'b0;
            cpu_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= ERR_NONE;
        end else begin
            ram_we <= 1'b0;
            if (fail) begin
                state   <= ERR;
                busy    <= 1'b0;
                done    <= 1'b0;
                cpu_rst <= 1'b1;
                error   <= fail_code;
            end else begin
                unique case (state)
                    IDLE, DONE, ERR: begin
                        if (accept && is_sync) begin
                            state   <= LEN;
                            busy    <= 1'b1;
                            cpu_rst <= 1'b1;
                            done    <= 1'b0;
                            error   <= ERR_NONE;
                        end
                    end
                    LEN: begin
                        if (accept) begin
                            remaining <= len_in[ADDR_W:0];
                            addr      <= '0;
                            sum       <= '0;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        if (accept) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= addr;
                            ram_data  <= in_data;
                            sum       <= sum + in_data;
                            remaining <= remaining - REM_ONE;
                            // Hold addr on the last byte so it never wraps.
                            if (remaining == REM_ONE) begin
                                state <= CSUM;
                            end else begin
                                addr <= addr + 1'b1;
                            end
                        end
                    end
                    CSUM: begin
                        if (accept) begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            cpu_rst <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
// One task per scenario; st = {busy,done,cpu_rst,error}, wr = {ram_we,ram_addr,ram_data}.
module tb_program_loader;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [5:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_we;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic [1:0] error;

    logic [4:0]  st;
    logic [14:0] wr;
    int n_cmp;
    int n_bad;
    int we_count;
    int snap;

    assign st = {busy, done, cpu_rst, error};
    assign wr = {ram_we, ram_addr, ram_data};

    program_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we === 1'b1) we_count++;

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (st !== 5'b00100) begin n_bad++; $display("FAIL reset_status: got %b want %b", st, 5'b00100); end
        n_cmp++; if (wr !== 15'h0) begin n_bad++; $display("FAIL reset_write: got %h want %h", wr, 15'h0); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", in_ready); end
        n_cmp++; if (st !== 5'b00100) begin n_bad++; $display("FAIL idle_status: got %b want %b", st, 5'b00100); end
    endtask

    task automatic test_good_frame;
        send(8'hA5);
        n_cmp++; if (st !== 5'b10100) begin n_bad++; $display("FAIL good_len_status: got %b want %b", st, 5'b10100); end
        send(8'h03);
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL good_no_we_on_len: got %b want 0", ram_we); end
        send(8'h11);
        n_cmp++; if (wr !== {1'b1, 6'd0, 8'h11}) begin n_bad++; $display("FAIL good_wr0: got %h want %h", wr, {1'b1, 6'd0, 8'h11}); end
        send(8'h22);
        n_cmp++; if (wr !== {1'b1, 6'd1, 8'h22}) begin n_bad++; $display("FAIL good_wr1: got %h want %h", wr, {1'b1, 6'd1, 8'h22}); end
        send(8'h33);
        n_cmp++; if (wr !== {1'b1, 6'd2, 8'h33}) begin n_bad++; $display("FAIL good_wr2: got %h want %h", wr, {1'b1, 6'd2, 8'h33}); end
        send(8'h66);
        n_cmp++; if (st !== 5'b01000) begin n_bad++; $display("FAIL good_done_status: got %b want %b", st, 5'b01000); end
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL good_no_we_on_csum: got %b want 0", ram_we); end
    endtask

    task automatic test_bad_csum;
        snap = we_count;
        send(8'hA5);
        send(8'h02);
        send(8'h01);
        n_cmp++; if (wr !== {1'b1, 6'd0, 8'h01}) begin n_bad++; $display("FAIL csum_wr0: got %h want %h", wr, {1'b1, 6'd0, 8'h01}); end
        send(8'h02);
        n_cmp++; if (wr !== {1'b1, 6'd1, 8'h02}) begin n_bad++; $display("FAIL csum_wr1: got %h want %h", wr, {1'b1, 6'd1, 8'h02}); end
        send(8'h04);
        n_cmp++; if (st !== 5'b00110) begin n_bad++; $display("FAIL csum_err_status: got %b want %b", st, 5'b00110); end
        n_cmp++; if (we_count - snap !== 2) begin n_bad++; $display("FAIL csum_write_count: got %0d want 2", we_count - snap); end
    endtask

    task automatic test_bad_len;
        snap = we_count;
        send(8'hA5);
        n_cmp++; if (st !== 5'b10100) begin n_bad++; $display("FAIL len_clear_err: got %b want %b", st, 5'b10100); end
        send(8'h00);
        n_cmp++; if (st !== 5'b00101) begin n_bad++; $display("FAIL len_zero: got %b want %b", st, 5'b00101); end
        send(8'hA5);
        send(8'h41);
        n_cmp++; if (st !== 5'b00101) begin n_bad++; $display("FAIL len_65: got %b want %b", st, 5'b00101); end
        @(posedge clk);
        #1;
        n_cmp++; if (we_count !== snap) begin n_bad++; $display("FAIL len_no_writes: got %0d want %0d", we_count, snap); end
        send(8'hA5);
        n_cmp++; if (st !== 5'b10100) begin n_bad++; $display("FAIL len_restart: got %b want %b", st, 5'b10100); end
        send(8'h01);
        send(8'h7F);
        n_cmp++; if (wr !== {1'b1, 6'd0, 8'h7F}) begin n_bad++; $display("FAIL len_recover_wr: got %h want %h", wr, {1'b1, 6'd0, 8'h7F}); end
        send(8'h7F);
        n_cmp++; if (st !== 5'b01000) begin n_bad++; $display("FAIL len_recover_done: got %b want %b", st, 5'b01000); end
    endtask

    task automatic test_timeout;
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        repeat (254) @(posedge clk);
        #1;
        n_cmp++; if (st !== 5'b10100) begin n_bad++; $display("FAIL tmo_254_still_busy: got %b want %b", st, 5'b10100); end
        @(posedge clk);
        #1;
        n_cmp++; if (st !== 5'b00111) begin n_bad++; $display("FAIL tmo_255_err: got %b want %b", st, 5'b00111); end
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        repeat (254) @(posedge clk);
        #1;
        send(8'h02);
        n_cmp++; if (st !== 5'b10100) begin n_bad++; $display("FAIL tmo_byte_wins: got %b want %b", st, 5'b10100); end
        n_cmp++; if (wr !== {1'b1, 6'd1, 8'h02}) begin n_bad++; $display("FAIL tmo_byte_wr: got %h want %h", wr, {1'b1, 6'd1, 8'h02}); end
        send(8'h03);
        send(8'h04);
        send(8'h0A);
        n_cmp++; if (st !== 5'b01000) begin n_bad++; $display("FAIL tmo_then_done: got %b want %b", st, 5'b01000); end
    endtask

    task automatic test_max_frame;
        send(8'hA5);
        send(8'h40);
        for (int i = 0; i < 64; i++) begin
            send(8'(i));
            n_cmp++; if (wr !== {1'b1, 6'(i), 8'(i)}) begin n_bad++; $display("FAIL max_wr%0d: got %h want %h", i, wr, {1'b1, 6'(i), 8'(i)}); end
        end
        send(8'hE0);
        n_cmp++; if (st !== 5'b01000) begin n_bad++; $display("FAIL max_done: got %b want %b", st, 5'b01000); end
        n_cmp++; if (wr !== {1'b0, 6'h3F, 8'h3F}) begin n_bad++; $display("FAIL max_no_wrap: got %h want %h", wr, {1'b0, 6'h3F, 8'h3F}); end
    endtask

    task automatic test_reset_restart;
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        rst = 1'b1;
        #1;
        n_cmp++; if (st !== 5'b00100) begin n_bad++; $display("FAIL rst_mid_status: got %b want %b", st, 5'b00100); end
        n_cmp++; if (wr !== 15'h0) begin n_bad++; $display("FAIL rst_mid_squash: got %h want %h", wr, 15'h0); end
        in_valid = 1'b1;
        in_data = 8'h03;
        @(posedge clk);
        #1;
        n_cmp++; if (wr !== 15'h0) begin n_bad++; $display("FAIL rst_hold_no_write: got %h want %h", wr, 15'h0); end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'hA5);
        send(8'h01);
        send(8'h55);
        send(8'h55);
        n_cmp++; if (st !== 5'b01000) begin n_bad++; $display("FAIL restart_done: got %b want %b", st, 5'b01000); end
        send(8'h12);
        n_cmp++; if (st !== 5'b01000) begin n_bad++; $display("FAIL done_ignores_byte: got %b want %b", st, 5'b01000); end
        send(8'hA5);
        n_cmp++; if (st !== 5'b10100) begin n_bad++; $display("FAIL done_resync: got %b want %b", st, 5'b10100); end
        send(8'h01);
        send(8'hA5);
        n_cmp++; if (wr !== {1'b1, 6'd0, 8'hA5}) begin n_bad++; $display("FAIL sync_as_payload: got %h want %h", wr, {1'b1, 6'd0, 8'hA5}); end
        send(8'hA5);
        n_cmp++; if (st !== 5'b01000) begin n_bad++; $display("FAIL sync_payload_done: got %b want %b", st, 5'b01000); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        we_count = 0;
        snap = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        test_reset;
        test_good_frame;
        test_bad_csum;
        test_bad_len;
        test_timeout;
        test_max_frame;
        test_reset_restart;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
